// File: rtl/minimac_rx_multislot.sv
// minimac_rx_multislot: MII/GMII byte assembly into NSLOTS slot buffers; ports: phy_rx_clk/phy_rx_rst, rx_ready in / rx_done out slot handshake, rx_count/rx_status per-slot results, rx_dropped no-slot counter, rxb_dat/rxb_adr/rxb_we buffer write port, phy_dv/phy_rx_data/phy_rx_er PHY stream
module minimac_rx_multislot #(
  parameter int NSLOTS = 4,
  parameter int ADDR_W = 11,
  parameter int PHY_W  = 4
) (
  input  logic                         phy_rx_clk,
  input  logic                         phy_rx_rst,
  input  logic [NSLOTS-1:0]            rx_ready,
  output logic [NSLOTS-1:0]            rx_done,
  output logic [NSLOTS*(ADDR_W+1)-1:0] rx_count,
  output logic [NSLOTS*3-1:0]          rx_status,
  output logic [15:0]                  rx_dropped,
  output logic [7:0]                   rxb_dat,
  output logic [ADDR_W-1:0]            rxb_adr,
  output logic [NSLOTS-1:0]            rxb_we,
  input  logic                         phy_dv,
  input  logic [PHY_W-1:0]             phy_rx_data,
  input  logic                         phy_rx_er
);
  localparam int CW = ADDR_W + 1;
  localparam int SW = NSLOTS > 1 ? $clog2(NSLOTS) : 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam bit MII = PHY_W == 4;
  typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, RECV, DISCARD, TERMINATE} state_t;
  state_t r_state, w_next;
  logic [NSLOTS-1:0] r_avail, w_onehot;
  logic [SW-1:0] r_slot, w_free_idx;
  logic [7:0] r_byte, w_in;
  logic [CW-1:0] w_cnt;
  logic w_free_any, w_start, w_drop, w_wr, w_end, w_odd;
  assign w_in = 8'(phy_rx_data);
  assign w_cnt = rx_count[r_slot*CW +: CW];
  assign w_onehot = NSLOTS'(1) << r_slot;
  assign w_free_any = |r_avail;
  assign rxb_dat = r_byte;
  assign rxb_adr = w_cnt[ADDR_W-1:0];
  assign rxb_we = (w_wr && w_cnt != DEPTH) ? w_onehot : '0;
  always_comb begin
    w_free_idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) if (r_avail[i]) w_free_idx = SW'(i);
  end
  always_comb begin
    w_next = r_state;
    w_start = 1'b0;
    w_drop = 1'b0;
    w_wr = 1'b0;
    w_end = 1'b0;
    w_odd = 1'b0;
    case (r_state)
      IDLE: if (phy_dv) begin
        w_start = w_free_any;
        w_drop = !w_free_any;
        w_next = !w_free_any ? DISCARD : MII ? LOAD_HI : RECV;
      end
      LOAD_HI: begin
        w_end = !phy_dv;
        w_odd = !phy_dv;
        w_next = phy_dv ? LOAD_LO : TERMINATE;
      end
      LOAD_LO, RECV: begin
        w_wr = 1'b1;
        w_end = !phy_dv;
        w_next = !phy_dv ? TERMINATE : MII ? LOAD_HI : RECV;
      end
      DISCARD: w_next = phy_dv ? DISCARD : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge phy_rx_clk) begin
    if (phy_rx_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge phy_rx_clk) begin
    if (phy_rx_rst) begin
      r_avail <= '0;
      r_slot <= '0;
      r_byte <= '0;
      rx_count <= '0;
      rx_status <= '0;
      rx_dropped <= '0;
      rx_done <= '0;
    end else begin
      r_avail <= (r_avail & ~rx_done) | rx_ready;
      rx_done <= w_end ? w_onehot : '0;
      if (w_drop && rx_dropped != 16'hFFFF) rx_dropped <= rx_dropped + 16'd1;
      if (phy_dv) begin
        if (!MII) r_byte <= w_in;
        else if (r_state == LOAD_HI) r_byte[7:4] <= w_in[3:0];
        else r_byte[3:0] <= w_in[3:0];
      end
      if (w_start) begin
        r_slot <= w_free_idx;
        rx_count[w_free_idx*CW +: CW] <= '0;
        rx_status[w_free_idx*3 +: 3] <= {2'b00, phy_rx_er};
      end else begin
        if (w_wr && w_cnt == DEPTH) rx_status[r_slot*3+1] <= 1'b1;
        if (w_wr && w_cnt != DEPTH) rx_count[r_slot*CW +: CW] <= w_cnt + 1'b1;
        if (phy_dv && phy_rx_er && r_state inside {LOAD_LO, LOAD_HI, RECV}) rx_status[r_slot*3] <= 1'b1;
        if (w_odd) rx_status[r_slot*3+2] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_minimac_rx_multislot.sv
// tb_minimac_rx_multislot: directed bench over MII (a), GMII (b) and small-buffer GMII (c) instances
module tb_minimac_rx_multislot;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0, epoch = 0, ep = -1;
  logic [3:0] a_ready = '0, a_done, a_we, a_data = '0;
  logic [47:0] a_count;
  logic [11:0] a_status;
  logic [15:0] a_drop;
  logic [7:0] a_dat;
  logic [10:0] a_adr;
  logic a_dv = 1'b0, a_er = 1'b0;
  logic [3:0] b_ready = '0, b_done, b_we;
  logic [47:0] b_count;
  logic [11:0] b_status;
  logic [15:0] b_drop;
  logic [7:0] b_dat, b_data = '0;
  logic [10:0] b_adr;
  logic b_dv = 1'b0, b_er = 1'b0;
  logic [1:0] c_ready = '0, c_done, c_we;
  logic [9:0] c_count;
  logic [5:0] c_status;
  logic [15:0] c_drop;
  logic [7:0] c_dat, c_data = '0;
  logic [3:0] c_adr;
  logic c_dv = 1'b0, c_er = 1'b0;
  int a_wn, b_wn, c_wn, a_dn, b_dn, c_dn, a_seq, b_seq, c_seq;
  logic [3:0] a_wor, a_dor, b_wor, b_dor;
  logic [1:0] c_wor, c_dor;
  logic [7:0] a_mem [0:2047];
  logic [7:0] b_mem [0:2047];
  logic [7:0] c_mem [0:15];
  minimac_rx_multislot #(.NSLOTS(4), .ADDR_W(11), .PHY_W(4)) u_a (
    .phy_rx_clk(clk), .phy_rx_rst(rst), .rx_ready(a_ready), .rx_done(a_done),
    .rx_count(a_count), .rx_status(a_status), .rx_dropped(a_drop), .rxb_dat(a_dat),
    .rxb_adr(a_adr), .rxb_we(a_we), .phy_dv(a_dv), .phy_rx_data(a_data), .phy_rx_er(a_er));
  minimac_rx_multislot #(.NSLOTS(4), .ADDR_W(11), .PHY_W(8)) u_b (
    .phy_rx_clk(clk), .phy_rx_rst(rst), .rx_ready(b_ready), .rx_done(b_done),
    .rx_count(b_count), .rx_status(b_status), .rx_dropped(b_drop), .rxb_dat(b_dat),
    .rxb_adr(b_adr), .rxb_we(b_we), .phy_dv(b_dv), .phy_rx_data(b_data), .phy_rx_er(b_er));
  minimac_rx_multislot #(.NSLOTS(2), .ADDR_W(4), .PHY_W(8)) u_c (
    .phy_rx_clk(clk), .phy_rx_rst(rst), .rx_ready(c_ready), .rx_done(c_done),
    .rx_count(c_count), .rx_status(c_status), .rx_dropped(c_drop), .rxb_dat(c_dat),
    .rxb_adr(c_adr), .rxb_we(c_we), .phy_dv(c_dv), .phy_rx_data(c_data), .phy_rx_er(c_er));
  always @(negedge clk) begin
    if (ep != epoch) begin
      ep = epoch;
      a_wn = 0; b_wn = 0; c_wn = 0; a_dn = 0; b_dn = 0; c_dn = 0; a_seq = 0; b_seq = 0; c_seq = 0;
      a_wor = '0; a_dor = '0; b_wor = '0; b_dor = '0; c_wor = '0; c_dor = '0;
    end
    if (a_we != 0) begin
      if (a_adr !== 11'(a_wn)) a_seq++;
      a_mem[a_adr] = a_dat; a_wn++; a_wor |= a_we;
    end
    if (b_we != 0) begin
      if (b_adr !== 11'(b_wn)) b_seq++;
      b_mem[b_adr] = b_dat; b_wn++; b_wor |= b_we;
    end
    if (c_we != 0) begin
      if (c_adr !== 4'(c_wn)) c_seq++;
      c_mem[c_adr] = c_dat; c_wn++; c_wor |= c_we;
    end
    if (a_done != 0) begin a_dn++; a_dor |= a_done; end
    if (b_done != 0) begin b_dn++; b_dor |= b_done; end
    if (c_done != 0) begin c_dn++; c_dor |= c_done; end
  end
  function automatic logic [7:0] a_byte(input int j);
    return 8'(j * 37 + 5);
  endfunction
  function automatic logic [7:0] b_byte(input int j);
    return 8'(j + 64);
  endfunction
  function automatic logic [7:0] c_byte(input int j);
    return 8'(240 - j);
  endfunction
  task automatic a_send(input int nnib);
    logic [7:0] v;
    for (int k = 0; k < nnib; k++) begin
      v = a_byte(k / 2);
      a_data = (k % 2 == 1) ? v[7:4] : v[3:0];
      a_dv = 1'b1;
      @(posedge clk); #1;
    end
    a_dv = 1'b0; a_data = '0;
  endtask
  task automatic b_send(input int n, input int er_at);
    for (int j = 0; j < n; j++) begin
      b_data = b_byte(j); b_er = (j == er_at); b_dv = 1'b1;
      @(posedge clk); #1;
    end
    b_dv = 1'b0; b_er = 1'b0; b_data = '0;
  endtask
  task automatic c_send(input int n);
    for (int j = 0; j < n; j++) begin
      c_data = c_byte(j); c_dv = 1'b1;
      @(posedge clk); #1;
    end
    c_dv = 1'b0; c_data = '0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({a_done, a_we, a_count, a_status, a_drop} !== '0) begin failures++; $display("FAIL rst_a got=%h exp=0", {a_done, a_we, a_count, a_status, a_drop}); end
    checks++; if ({b_done, b_we, b_count, b_status, b_drop} !== '0) begin failures++; $display("FAIL rst_b got=%h exp=0", {b_done, b_we, b_count, b_status, b_drop}); end
    checks++; if ({c_done, c_we, c_count, c_status, c_drop} !== '0) begin failures++; $display("FAIL rst_c got=%h exp=0", {c_done, c_we, c_count, c_status, c_drop}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_mii_frame;
    int bad;
    a_ready = 4'b0110; @(posedge clk); #1; a_ready = '0; @(posedge clk); #1;
    epoch++;
    a_send(128);
    repeat (4) @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < 64; j++) if (a_mem[j] !== a_byte(j)) bad++;
    checks++; if (a_wor !== 4'b0010) begin failures++; $display("FAIL mii_we_slot got=%b exp=0010", a_wor); end
    checks++; if (a_wn != 64 || a_seq != 0) begin failures++; $display("FAIL mii_writes got=%0d seq_err=%0d exp=64/0", a_wn, a_seq); end
    checks++; if (bad != 0) begin failures++; $display("FAIL mii_data got=%0d bad exp=0", bad); end
    checks++; if (a_dor !== 4'b0010 || a_dn != 1) begin failures++; $display("FAIL mii_done got=%b x%0d exp=0010 x1", a_dor, a_dn); end
    checks++; if (a_count[12 +: 12] !== 12'd64) begin failures++; $display("FAIL mii_count1 got=%0d exp=64", a_count[12 +: 12]); end
    checks++; if (a_status[3 +: 3] !== 3'b000) begin failures++; $display("FAIL mii_status1 got=%b exp=000", a_status[3 +: 3]); end
    checks++; if ({a_count[0 +: 12], a_count[24 +: 24]} !== '0) begin failures++; $display("FAIL mii_other_counts got=%h exp=0", {a_count[0 +: 12], a_count[24 +: 24]}); end
  endtask
  task automatic test_gmii_error;
    int bad;
    b_ready = 4'b0001; @(posedge clk); #1; b_ready = '0; @(posedge clk); #1;
    epoch++;
    b_send(60, 10);
    @(negedge clk);
    checks++; if (b_we !== 4'b0001 || b_adr !== 11'd59 || b_dat !== b_byte(59)) begin failures++; $display("FAIL gmii_last_wr got=%b/%0d/%h exp=0001/59/%h", b_we, b_adr, b_dat, b_byte(59)); end
    checks++; if (b_done !== 4'b0000) begin failures++; $display("FAIL gmii_done_early got=%b exp=0000", b_done); end
    @(negedge clk);
    checks++; if (b_done !== 4'b0001) begin failures++; $display("FAIL gmii_done got=%b exp=0001", b_done); end
    repeat (3) @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < 60; j++) if (b_mem[j] !== b_byte(j)) bad++;
    checks++; if (b_count[0 +: 12] !== 12'd60) begin failures++; $display("FAIL gmii_count got=%0d exp=60", b_count[0 +: 12]); end
    checks++; if (b_status[0 +: 3] !== 3'b001) begin failures++; $display("FAIL gmii_status got=%b exp=001", b_status[0 +: 3]); end
    checks++; if (b_wn != 60 || b_seq != 0 || bad != 0 || b_dn != 1) begin failures++; $display("FAIL gmii_writes got=%0d seq=%0d bad=%0d done=%0d exp=60/0/0/1", b_wn, b_seq, bad, b_dn); end
  endtask
  task automatic test_mii_odd;
    epoch++;
    a_send(7);
    repeat (4) @(posedge clk); #1;
    checks++; if (a_wor !== 4'b0100 || a_wn != 3) begin failures++; $display("FAIL odd_writes got=%b x%0d exp=0100 x3", a_wor, a_wn); end
    checks++; if (a_mem[0] !== a_byte(0) || a_mem[1] !== a_byte(1) || a_mem[2] !== a_byte(2)) begin failures++; $display("FAIL odd_data got=%h%h%h exp=%h%h%h", a_mem[0], a_mem[1], a_mem[2], a_byte(0), a_byte(1), a_byte(2)); end
    checks++; if (a_count[24 +: 12] !== 12'd3) begin failures++; $display("FAIL odd_count got=%0d exp=3", a_count[24 +: 12]); end
    checks++; if (a_status[6 +: 3] !== 3'b100) begin failures++; $display("FAIL odd_status got=%b exp=100", a_status[6 +: 3]); end
    checks++; if (a_dor !== 4'b0100 || a_dn != 1) begin failures++; $display("FAIL odd_done got=%b x%0d exp=0100 x1", a_dor, a_dn); end
    checks++; if (a_count[12 +: 12] !== 12'd64) begin failures++; $display("FAIL odd_prev_count got=%0d exp=64", a_count[12 +: 12]); end
  endtask
  task automatic test_overflow;
    int bad;
    c_ready = 2'b01; @(posedge clk); #1; c_ready = '0; @(posedge clk); #1;
    epoch++;
    c_send(20);
    repeat (4) @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < 16; j++) if (c_mem[j] !== c_byte(j)) bad++;
    checks++; if (c_wn != 16 || c_seq != 0 || c_wor !== 2'b01) begin failures++; $display("FAIL ovf_writes got=%0d seq=%0d we=%b exp=16/0/01", c_wn, c_seq, c_wor); end
    checks++; if (bad != 0) begin failures++; $display("FAIL ovf_data got=%0d bad exp=0", bad); end
    checks++; if (c_count[0 +: 5] !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", c_count[0 +: 5]); end
    checks++; if (c_status[0 +: 3] !== 3'b010) begin failures++; $display("FAIL ovf_status got=%b exp=010", c_status[0 +: 3]); end
    checks++; if (c_dor !== 2'b01 || c_dn != 1) begin failures++; $display("FAIL ovf_done got=%b x%0d exp=01 x1", c_dor, c_dn); end
  endtask
  task automatic test_drop;
    epoch++;
    for (int f = 0; f < 3; f++) begin
      b_send(5, -1);
      repeat (2) @(posedge clk); #1;
    end
    checks++; if (b_wn != 0 || b_dn != 0) begin failures++; $display("FAIL drop_activity got=%0d writes %0d done exp=0/0", b_wn, b_dn); end
    checks++; if (b_drop !== 16'd3) begin failures++; $display("FAIL drop_count got=%0d exp=3", b_drop); end
    checks++; if (b_count[0 +: 12] !== 12'd60) begin failures++; $display("FAIL drop_keep_count got=%0d exp=60", b_count[0 +: 12]); end
  endtask
  task automatic test_ready_done_same;
    b_ready = 4'b0001; @(posedge clk); #1; b_ready = '0; @(posedge clk); #1;
    b_send(4, -1);
    @(posedge clk); #1;
    b_ready = 4'b0001;
    checks++; if (b_done !== 4'b0001) begin failures++; $display("FAIL same_done_pulse got=%b exp=0001", b_done); end
    @(posedge clk); #1;
    b_ready = '0;
    repeat (2) @(posedge clk); #1;
    epoch++;
    b_send(6, -1);
    repeat (4) @(posedge clk); #1;
    checks++; if (b_dor !== 4'b0001 || b_wn != 6) begin failures++; $display("FAIL same_reuse got=%b x%0d exp=0001 x6", b_dor, b_wn); end
    checks++; if (b_count[0 +: 12] !== 12'd6 || b_drop !== 16'd3) begin failures++; $display("FAIL same_count got=%0d drop=%0d exp=6/3", b_count[0 +: 12], b_drop); end
  endtask
  task automatic test_reset_mid;
    a_ready = 4'b0001; @(posedge clk); #1; a_ready = '0; @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      a_data = 4'(k); a_dv = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({a_done, a_we, a_count, a_status, a_drop} !== '0) begin failures++; $display("FAIL rstmid_a got=%h exp=0", {a_done, a_we, a_count, a_status, a_drop}); end
    checks++; if (b_drop !== 16'd0 || b_count !== '0) begin failures++; $display("FAIL rstmid_b got=%0d/%h exp=0/0", b_drop, b_count); end
    rst = 1'b0; a_dv = 1'b0; a_data = '0;
    epoch++;
    repeat (2) @(posedge clk); #1;
    a_send(4);
    repeat (3) @(posedge clk); #1;
    checks++; if (a_drop !== 16'd1 || a_wn != 0 || a_dn != 0) begin failures++; $display("FAIL rstmid_drop got=%0d/%0d/%0d exp=1/0/0", a_drop, a_wn, a_dn); end
    a_ready = 4'b0001; @(posedge clk); #1; a_ready = '0; @(posedge clk); #1;
    a_send(4);
    repeat (3) @(posedge clk); #1;
    checks++; if (a_count[0 +: 12] !== 12'd2 || a_dor !== 4'b0001 || a_wn != 2) begin failures++; $display("FAIL rstmid_reoffer got=%0d/%b/%0d exp=2/0001/2", a_count[0 +: 12], a_dor, a_wn); end
  endtask
  initial begin
    test_reset;
    test_mii_frame;
    test_gmii_error;
    test_mii_odd;
    test_overflow;
    test_drop;
    test_ready_done_same;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/minimac_rx_multislot.md
Name: minimac_rx_multislot

Overview:
- Parametrised successor of the MAC receive datapath. Runs entirely in the PHY receive clock domain.
- Assembles bytes from an MII (4-bit) or GMII (8-bit) PHY stream and writes them into one of NSLOTS per-slot packet buffers.
- Reports per-slot byte counts and error status. Counts frames dropped because no slot was free.
- Sits between the PHY pins and the slot buffer RAMs. The slot handshake (rx_ready/rx_done) is resynchronised to the system side elsewhere.

Parameters:
- NSLOTS, 4, number of receive slots (1..8); lower index = higher priority.
- ADDR_W, 11, slot buffer address width; DEPTH = 2^ADDR_W bytes per slot.
- PHY_W, 4, PHY data width: 4 = MII (nibble pairs, low nibble first), 8 = GMII (one byte per cycle).

Ports:
- phy_rx_clk  in  1  receive clock; all logic is on the rising edge.
- phy_rx_rst  in  1  reset, synchronous, active-high.
- rx_ready  in  NSLOTS  per-slot pulse: slot buffer handed to receiver (free).
- rx_done  out  NSLOTS  one-cycle pulse: frame complete in that slot.
- rx_count  out  NSLOTS*(ADDR_W+1)  per-slot byte count, slot i at bits [i*(ADDR_W+1) +: ADDR_W+1].
- rx_status  out  NSLOTS*3  per-slot flags, slot i at [i*3 +: 3]: bit0 phy_rx_er seen, bit1 overflow, bit2 odd nibble (MII only).
- rx_dropped  out  16  saturating count of frames dropped for lack of a free slot.
- rxb_dat  out  8  byte to write, shared by all slots.
- rxb_adr  out  ADDR_W  write address = low ADDR_W bits of the active slot's count.
- rxb_we  out  NSLOTS  write enable, one-hot on the active slot.
- phy_dv  in  1  PHY data valid.
- phy_rx_data  in  PHY_W  PHY data.
- phy_rx_er  in  1  PHY receive error.

Behaviour:
- Reset values: available = 0, state IDLE, all rx_count = 0, all rx_status = 0, rx_dropped = 0, rx_done = 0, rxb_we = 0.
- Availability register: available <= (available & ~rx_done) | rx_ready. rx_ready wins when it coincides with rx_done on the same bit.
- States: IDLE, LOAD_LO, LOAD_HI (MII only), RECV (GMII only), DISCARD, TERMINATE.
- IDLE: active slot = lowest set bit of available, re-evaluated every cycle.
  - On phy_dv with a slot free: latch the active slot, clear its count and status, capture the first sample.
  - MII then goes to LOAD_HI; GMII captures a full byte and goes to RECV.
  - On phy_dv with no slot free: rx_dropped += 1 (saturating at 0xFFFF), go to DISCARD.
- MII: LOAD_HI with dv captures the high nibble and goes to LOAD_LO. LOAD_LO writes the byte; with dv it captures the next low nibble and goes to LOAD_HI.
- GMII: RECV writes the previously captured byte and, while dv, captures the next one.
- Write latency: rxb_we pulses in the cycle after the sample that completes the byte. In that same cycle the count increments, and rxb_adr equals the pre-increment count.
- Overflow: when the count equals DEPTH, writes and increments are suppressed, status bit1 is set, and reception continues to frame end. Count saturates at DEPTH.
- phy_rx_er sampled high while dv is high sets status bit0 for the frame.
- Frame end: first cycle dv is low in any receive state.
  - rx_done pulses for the active slot.
  - Any byte completed in the previous cycle is written in this same cycle.
  - If dv falls in LOAD_HI (dangling low nibble), that nibble is discarded and status bit2 is set.
  - Then TERMINATE for one cycle, then IDLE.
- Visibility: count and status are final and stable from the cycle after rx_done until the next frame start on that slot.
- DISCARD: no writes; wait for dv low, then IDLE. It does not pass through TERMINATE and produces no rx_done.
- phy_rx_rst mid-frame: return to reset values next cycle. No rx_done is issued, and freed slots must be re-offered via rx_ready.

Test Plan:
- MII, NSLOTS=4, rx_ready=4'b0110 then a 64-byte frame (128 nibbles) -> writes into slot 1 only, addresses 0..63, rx_done=4'b0010, count1=64, status1=0.
- GMII, 60-byte frame with phy_rx_er high on byte 10 -> count=60, status bit0=1, done one cycle after dv falls.
- MII, 7-nibble frame -> count=3, status bit2=1, dangling nibble not written.
- ADDR_W=4, 20-byte frame -> writes to addresses 0..15 only, count=16, status bit1=1.
- available=0, three frames -> no writes, no rx_done, rx_dropped=3. rx_ready and rx_done on the same bit in one cycle -> slot remains available.
- phy_rx_rst asserted mid-frame -> all outputs at reset values next cycle; a following frame is dropped until rx_ready is pulsed.
